mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative radix-2 multiply/divide unit. It retires one partial-product or
// quotient bit per clock and writes the result into the architectural HI/LO
// registers.
//
// Optional feature macro: MDU_DIV_EN
//   defined   : the divide datapath is built and DIVU/DIV compute normally.
//   undefined : only multiply hardware is built. DIVU/DIV finish in one cycle
//               with err_o=1 and HI/LO left unchanged.
//
// Parameters
//   WIDTH        operand width (even, >= 4)
//
// Ports
//   clk_i        clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      request, sampled only in IDLE
//   op_i[1:0]    00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start_i)
//   src1_i       multiplicand / dividend
//   src2_i       multiplier / divisor
//   flush_i      abort the operation in flight
//   busy_o       operation in flight (RUN or FIX)
//   done_o       one-cycle pulse after HI/LO have been updated
//   err_o        divide by zero, or a divide op in a build without divide
//   hi_o         product upper half / remainder
//   lo_o         product lower half / quotient
//   dbg_state_o  current FSM state (00 IDLE, 01 RUN, 10 FIX)
//
// Handshake: a request is accepted on a rising edge where the unit is IDLE,
// start_i=1 and flush_i=0. busy_o is high from the following cycle until the
// commit edge. done_o is high for exactly the one cycle after the commit
// edge, and a new start_i can be accepted in that same cycle. A start_i
// seen while busy_o=1 is dropped, not queued.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Control strobes from the output process.
  logic accept;
  logic step;
  logic commit;

  // Datapath state.
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // {HI-side, LO-side} working register
  logic [WIDTH-1:0]     opb_q, opb_d;   // multiplicand or divisor magnitude
  logic                 neg_q, neg_d;   // result (product/quotient) is negative
  logic                 trap_q, trap_d; // op completes without iterating
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
`ifdef MDU_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 neg_rem_q, neg_rem_d; // remainder follows dividend sign
`endif

  // -------------------------------------------------------------------------
  // Operand decode (only consumed on the accept edge)
  // -------------------------------------------------------------------------
  logic             s1_neg, s2_neg;
  logic [WIDTH-1:0] mag1, mag2;
  logic             quick;  // IDLE -> FIX without iterating

  always_comb begin
    s1_neg = op_i[0] & src1_i[WIDTH-1];
    s2_neg = op_i[0] & src2_i[WIDTH-1];
    mag1   = s1_neg ? ('0 - src1_i) : src1_i;
    mag2   = s2_neg ? ('0 - src2_i) : src2_i;
`ifdef MDU_DIV_EN
    quick  = op_i[1] & (src2_i == '0);
`else
    quick  = op_i[1];
`endif
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) state_d = quick ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        if (flush_i)                        state_d = ST_IDLE;
        else if (cnt_q == CW'(WIDTH - 1))   state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs (datapath strobes)
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    case (state_q)
      ST_IDLE: accept = start_i & ~flush_i;
      ST_RUN:  step   = ~flush_i;
      ST_FIX:  commit = ~flush_i;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // One iteration of each datapath
  // -------------------------------------------------------------------------
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift right keeping the carry.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  // Restoring divide: shift the next dividend bit into the partial remainder
  // and subtract the divisor. The partial remainder is always below twice the
  // divisor, so bit WIDTH of the difference is a clean borrow flag.
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_part - {1'b0, opb_q};
    div_ge   = ~div_diff[WIDTH];
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end
`endif

  // -------------------------------------------------------------------------
  // Sign correction for the commit
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  always_comb begin
    prod_fix = neg_q ? ('0 - acc_q) : acc_q;
  end

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] quo_fix, rem_fix;
  always_comb begin
    quo_fix = neg_q     ? ('0 - acc_q[WIDTH-1:0])         : acc_q[WIDTH-1:0];
    rem_fix = neg_rem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH])   : acc_q[2*WIDTH-1:WIDTH];
  end
`endif

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
    neg_d  = neg_q;
    trap_d = trap_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    err_d  = err_q;
    done_d = commit;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif

    if (accept) begin
      cnt_d  = '0;
      err_d  = 1'b0;
      trap_d = quick;
      neg_d  = s1_neg ^ s2_neg;
`ifdef MDU_DIV_EN
      is_div_d  = op_i[1];
      neg_rem_d = s1_neg;
      if (quick) begin
        // Divide by zero: the raw commit value is staged in acc.
        acc_d = {src1_i, {WIDTH{1'b1}}};
      end else if (op_i[1]) begin
        acc_d = {{WIDTH{1'b0}}, mag1};
        opb_d = mag2;
      end else begin
        acc_d = {{WIDTH{1'b0}}, mag2};
        opb_d = mag1;
      end
`else
      if (!op_i[1]) begin
        acc_d = {{WIDTH{1'b0}}, mag2};
        opb_d = mag1;
      end
`endif
    end

    if (step) begin
      cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
      acc_d = is_div_q ? div_next : mul_next;
`else
      acc_d = mul_next;
`endif
    end

    if (commit) begin
      if (trap_q) begin
        err_d = 1'b1;
`ifdef MDU_DIV_EN
        hi_d  = acc_q[2*WIDTH-1:WIDTH];
        lo_d  = acc_q[WIDTH-1:0];
`endif
      end else begin
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`else
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      trap_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      trap_q    <= trap_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      err_q     <= err_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbg_state_o = state_q;

endmodule
